adc_spi_capture: RTL and testbench

- Parametrised successor of the single-channel serial-ADC capture path.
- Generates chip select (CS) and the serial clock (SCLK) from the system clock with an internal divider, so no separate clock domain is needed.
- Deserialises one MSB-first frame per data line on up to CHANNELS parallel lines (for example, both AD7476-class converters of a dual Pmod).
- Supports single-shot and continuous conversion, a valid/ack result handshake, and sticky overrun detection.

---
 rtl/adc_pkg.sv | 22 ++
 rtl/adc_sclk_gen.sv | 44 ++++
 rtl/adc_spi_capture.sv | 139 +++++++++++++
 tb/tb_adc_spi_capture.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and defaults for the multi-channel serial ADC capture path.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    QUIET = 2'd2
  } state_e;

  localparam int DEF_CLK_DIV      = 4;
  localparam int DEF_CHANNELS     = 2;
  localparam int DEF_FRAME_BITS   = 16;
  localparam int DEF_LEAD_BITS    = 4;
  localparam int DEF_DATA_BITS    = 12;
  localparam int DEF_QUIET_CYCLES = 8;

  // Base bit index of channel `chan` in a bus packed `width` bits per channel.
  function automatic int chan_offset(input int chan, input int width);
    return chan * width;
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK generator: toggles every CLK_DIV enabled cycles, idles high while cleared,
// and flags the cycle in which SCLK is about to go 0->1.
module adc_sclk_gen #(
  parameter int CLK_DIV = adc_pkg::DEF_CLK_DIV
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic sclk,
  output logic rise_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          wrap;

  assign wrap      = (cnt_q == CW'(CLK_DIV - 1));
  assign rise_tick = enable && !clear && wrap && !sclk_q;
  assign sclk      = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (clear) begin
      cnt_d  = '0;
      sclk_d = 1'b1;
    end else if (enable) begin
      if (wrap) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    sclk_q <= sclk_d;
  end

endmodule

// File: rtl/adc_spi_capture.sv
// Serial ADC capture: drives CS/SCLK, deserialises one MSB-first frame per channel,
// and hands results to a consumer with valid/ack plus sticky overrun.
module adc_spi_capture
  import adc_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int FRAME_BITS   = DEF_FRAME_BITS,
  parameter int LEAD_BITS    = DEF_LEAD_BITS,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int QUIET_CYCLES = DEF_QUIET_CYCLES
) (
  input  logic                            Clock_Nexys,
  input  logic                            Reset,
  input  logic                            start,
  input  logic                            continuous,
  input  logic [CHANNELS-1:0]             data_ADC,
  input  logic                            ack,
  output logic                            CS,
  output logic                            Clock_Muestreo,
  output logic                            busy,
  output logic                            done,
  output logic                            valid,
  output logic                            overrun,
  output logic [CHANNELS*DATA_BITS-1:0]   Dato,
  output logic [CHANNELS*LEAD_BITS-1:0]   data_basura,
  output state_e                          state_dbg
);

  localparam int BCW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int QCW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

  state_e                               state_q, state_d;
  logic [BCW-1:0]                       bit_cnt_q, bit_cnt_d;
  logic [QCW-1:0]                       quiet_cnt_q, quiet_cnt_d;
  logic [CHANNELS-1:0][FRAME_BITS-1:0]  shift_q, shift_d;
  logic [CHANNELS*DATA_BITS-1:0]        dato_q, dato_d;
  logic [CHANNELS*LEAD_BITS-1:0]        basura_q, basura_d;
  logic                                 done_q, done_d;
  logic                                 valid_q, valid_d;
  logic                                 overrun_q, overrun_d;
  logic                                 sclk_clear, rise_tick;

  // The divider only runs in FRAME, so each frame starts from a clean phase.
  assign sclk_clear = Reset || (state_q != FRAME);

  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (Clock_Nexys),
    .clear     (sclk_clear),
    .enable    (state_q == FRAME),
    .sclk      (Clock_Muestreo),
    .rise_tick (rise_tick)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    quiet_cnt_d = quiet_cnt_q;
    shift_d     = shift_q;
    dato_d      = dato_q;
    basura_d    = basura_q;
    done_d      = 1'b0;
    valid_d     = valid_q;
    overrun_d   = overrun_q;

    // An ack seen alongside the done pulse belongs to the old result, so the new one stays valid.
    if (ack && valid_q && !done_q) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = FRAME;
      end
      FRAME: begin
        if (rise_tick) begin
          for (int c = 0; c < CHANNELS; c++)
            shift_d[c] = {shift_q[c][FRAME_BITS-2:0], data_ADC[c]};
          if (bit_cnt_q == BCW'(FRAME_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = QUIET;
            done_d    = 1'b1;
            valid_d   = 1'b1;
            if (valid_q && !ack) overrun_d = 1'b1;
            for (int c = 0; c < CHANNELS; c++) begin
              dato_d[chan_offset(c, DATA_BITS) +: DATA_BITS] =
                shift_d[c][FRAME_BITS-1-LEAD_BITS -: DATA_BITS];
              basura_d[chan_offset(c, LEAD_BITS) +: LEAD_BITS] =
                shift_d[c][FRAME_BITS-1 -: LEAD_BITS];
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      QUIET: begin
        if (quiet_cnt_q == QCW'(QUIET_CYCLES - 1)) begin
          quiet_cnt_d = '0;
          state_d     = continuous ? FRAME : IDLE;
        end else begin
          quiet_cnt_d = quiet_cnt_q + QCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock_Nexys) begin
    if (Reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      quiet_cnt_q <= '0;
      shift_q     <= '0;
      dato_q      <= '0;
      basura_q    <= '0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      quiet_cnt_q <= quiet_cnt_d;
      shift_q     <= shift_d;
      dato_q      <= dato_d;
      basura_q    <= basura_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign CS          = (state_q != FRAME);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign valid       = valid_q;
  assign overrun     = overrun_q;
  assign Dato        = dato_q;
  assign data_basura = basura_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Bench for adc_spi_capture: a converter model serves frame words on the data lines
// and results are compared against an arithmetic model of the frame layout.
module tb_adc_spi_capture;
  import adc_pkg::*;

  localparam int DIV = 4;
  localparam int CH  = 2;
  localparam int FB  = 16;
  localparam int LB  = 4;
  localparam int DB  = 12;
  localparam int QC  = 8;

  logic                 clk = 1'b0;
  logic                 Reset = 1'b1;
  logic                 start = 1'b0;
  logic                 continuous = 1'b0;
  logic [CH-1:0]        data_ADC = '0;
  logic                 ack = 1'b0;
  logic                 CS, Clock_Muestreo, busy, done, valid, overrun;
  logic [CH*DB-1:0]     Dato;
  logic [CH*LB-1:0]     data_basura;
  state_e               state_dbg;

  int checks = 0;
  int fails  = 0;

  logic [CH-1:0][FB-1:0] frame_w = '0;
  logic [CH*DB-1:0]      exp_q[$];

  adc_spi_capture #(
    .CLK_DIV(DIV), .CHANNELS(CH), .FRAME_BITS(FB),
    .LEAD_BITS(LB), .DATA_BITS(DB), .QUIET_CYCLES(QC)
  ) dut (
    .Clock_Nexys(clk), .Reset(Reset), .start(start), .continuous(continuous),
    .data_ADC(data_ADC), .ack(ack), .CS(CS), .Clock_Muestreo(Clock_Muestreo),
    .busy(busy), .done(done), .valid(valid), .overrun(overrun),
    .Dato(Dato), .data_basura(data_basura), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- converter model ----------------
  // Bit k of the frame (MSB first) is presented after k SCLK rising edges.
  int   bit_idx   = 0;
  logic sclk_prev = 1'b1;
  always @(posedge clk) begin
    #1;
    if (CS === 1'b1) bit_idx = 0;
    else if (Clock_Muestreo === 1'b1 && sclk_prev === 1'b0) bit_idx++;
    sclk_prev = Clock_Muestreo;
    for (int c = 0; c < CH; c++)
      data_ADC[c] = (bit_idx < FB) ? frame_w[c][FB-1-bit_idx] : 1'b0;
  end

  // ---------------- reference model ----------------
  function automatic logic [CH*DB-1:0] model_dato(input logic [CH-1:0][FB-1:0] w);
    logic [CH*DB-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++)
      r[c*DB +: DB] = DB'((int'(w[c]) >> (FB - LB - DB)) % (1 << DB));
    return r;
  endfunction

  function automatic logic [CH*LB-1:0] model_lead(input logic [CH-1:0][FB-1:0] w);
    logic [CH*LB-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++)
      r[c*LB +: LB] = LB'(int'(w[c]) >> (FB - LB));
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Counts CS-low cycles starting from the cycle right after CS falls.
  task automatic count_cs_low(output int n);
    int k;
    n = (CS === 1'b0) ? 1 : 0;
    k = 0;
    while (CS === 1'b0 && k < 1000) begin
      tick();
      k++;
      if (CS === 1'b0) n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
    checks++; if (CS !== 1'b1) begin fails++; $display("FAIL reset_cs: got %b want 1", CS); end
    checks++; if (Clock_Muestreo !== 1'b1) begin fails++; $display("FAIL reset_sclk: got %b want 1", Clock_Muestreo); end
    checks++; if ({busy, done, valid, overrun} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b want 0000", {busy, done, valid, overrun}); end
    checks++; if (Dato !== '0) begin fails++; $display("FAIL reset_dato: got %h want 0", Dato); end
    checks++; if (data_basura !== '0) begin fails++; $display("FAIL reset_basura: got %h want 0", data_basura); end
  endtask

  task automatic test_single_shot();
    int n;
    frame_w[0] = 16'h0ABC;
    frame_w[1] = 16'h0123;
    pulse_start();
    checks++; if (CS !== 1'b0) begin fails++; $display("FAIL single_cs_fall: got %b want 0", CS); end
    count_cs_low(n);
    checks++; if (n != 2 * DIV * FB) begin fails++; $display("FAIL single_cs_low_len: got %0d want %0d", n, 2 * DIV * FB); end
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL single_done_cycle: got %b want 1", done); end
    checks++; if (Dato !== 24'h123ABC) begin fails++; $display("FAIL single_dato: got %h want 123abc", Dato); end
    checks++; if (Dato !== model_dato(frame_w)) begin fails++; $display("FAIL single_dato_model: got %h want %h", Dato, model_dato(frame_w)); end
    checks++; if (data_basura !== 8'h00) begin fails++; $display("FAIL single_basura: got %h want 00", data_basura); end
    checks++; if (valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", valid); end
    tick();
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL single_done_width: got %b want 0", done); end
    repeat (QC - 2) tick();
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_quiet: got %b want 1", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_leading_bits();
    bit seen, idle;
    pulse_ack();
    frame_w[0] = 16'hF555;
    frame_w[1] = 16'($urandom);
    pulse_start();
    wait_done(400, seen);
    checks++; if (!seen) begin fails++; $display("FAIL lead_timeout: got no done want done"); end
    checks++; if (data_basura[3:0] !== 4'hF) begin fails++; $display("FAIL lead_basura0: got %h want f", data_basura[3:0]); end
    checks++; if (Dato[11:0] !== 12'h555) begin fails++; $display("FAIL lead_dato0: got %h want 555", Dato[11:0]); end
    checks++; if (data_basura !== model_lead(frame_w)) begin fails++; $display("FAIL lead_basura_model: got %h want %h", data_basura, model_lead(frame_w)); end
    checks++; if (Dato !== model_dato(frame_w)) begin fails++; $display("FAIL lead_dato_model: got %h want %h", Dato, model_dato(frame_w)); end
    wait_idle(50, idle);
  endtask

  task automatic test_continuous();
    bit seen, idle;
    int dones, hi, k;
    logic [CH*DB-1:0] exp;
    pulse_ack();
    dones = 0;
    frame_w[0] = 16'h0001;
    frame_w[1] = 16'($urandom);
    exp_q.push_back(model_dato(frame_w));
    continuous = 1'b1;
    pulse_start();
    for (int f = 0; f < 3; f++) begin
      wait_done(400, seen);
      checks++; if (!seen) begin fails++; $display("FAIL cont_timeout: frame %0d got no done", f); end
      if (seen) dones++;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      checks++; if (Dato !== exp) begin fails++; $display("FAIL cont_dato: frame %0d got %h want %h", f, Dato, exp); end
      if (f < 2) begin
        frame_w[0] = 16'(f + 2);
        frame_w[1] = 16'($urandom);
        exp_q.push_back(model_dato(frame_w));
        hi = 1;
        k  = 0;
        while (CS === 1'b1 && k < 40) begin
          ack = (k == 2);
          tick();
          k++;
          if (CS === 1'b1) hi++;
        end
        ack = 1'b0;
        checks++; if (hi != QC) begin fails++; $display("FAIL cont_quiet_len: frame %0d got %0d want %0d", f, hi, QC); end
        if (f == 1) continuous = 1'b0;
      end else begin
        repeat (2) tick();
        pulse_ack();
      end
    end
    wait_idle(50, idle);
    checks++; if (dones != 3) begin fails++; $display("FAIL cont_done_count: got %0d want 3", dones); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL cont_overrun: got %b want 0", overrun); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL cont_idle: got %b want 0", busy); end
  endtask

  task automatic test_overrun();
    bit seen, idle;
    int k;
    logic [CH-1:0][FB-1:0] second;
    frame_w[0] = 16'($urandom);
    frame_w[1] = 16'($urandom);
    continuous = 1'b1;
    pulse_start();
    wait_done(400, seen);
    checks++; if (!seen) begin fails++; $display("FAIL ovr_timeout1: got no done"); end
    checks++; if ({valid, overrun} !== 2'b10) begin fails++; $display("FAIL ovr_first: got %b want 10", {valid, overrun}); end
    second = {16'($urandom), 16'($urandom)};
    frame_w = second;
    k = 0;
    while (CS !== 1'b0 && k < 40) begin tick(); k++; end
    continuous = 1'b0;
    wait_done(400, seen);
    checks++; if (!seen) begin fails++; $display("FAIL ovr_timeout2: got no done"); end
    checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b want 1", overrun); end
    checks++; if (Dato !== model_dato(second)) begin fails++; $display("FAIL ovr_dato: got %h want %h", Dato, model_dato(second)); end
    wait_idle(50, idle);
    pulse_ack();
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL ovr_ack_valid: got %b want 0", valid); end
    checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_reset_mid_frame();
    bit seen, idle;
    int rises, k, n;
    logic prev;
    frame_w = {16'($urandom), 16'($urandom)};
    pulse_start();
    prev  = Clock_Muestreo;
    rises = 0;
    k     = 0;
    while (rises < 7 && k < 500) begin
      tick();
      k++;
      if (Clock_Muestreo === 1'b1 && prev === 1'b0) rises++;
      prev = Clock_Muestreo;
    end
    checks++; if (rises != 7) begin fails++; $display("FAIL rst_mid_rises: got %0d want 7", rises); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++; if ({CS, Clock_Muestreo, busy} !== 3'b110) begin fails++; $display("FAIL rst_mid_lines: got %b want 110", {CS, Clock_Muestreo, busy}); end
    checks++; if (Dato !== '0) begin fails++; $display("FAIL rst_mid_dato: got %h want 0", Dato); end
    checks++; if ({valid, overrun} !== 2'b00) begin fails++; $display("FAIL rst_mid_flags: got %b want 00", {valid, overrun}); end
    tick();
    frame_w = {16'($urandom), 16'($urandom)};
    pulse_start();
    count_cs_low(n);
    checks++; if (n != 2 * DIV * FB) begin fails++; $display("FAIL rst_mid_refr_len: got %0d want %0d", n, 2 * DIV * FB); end
    wait_done(4, seen);
    checks++; if (!seen) begin fails++; $display("FAIL rst_mid_refr_done: got no done"); end
    checks++; if (Dato !== model_dato(frame_w)) begin fails++; $display("FAIL rst_mid_refr_dato: got %h want %h", Dato, model_dato(frame_w)); end
    wait_idle(50, idle);
  endtask

  task automatic test_ack_with_done();
    bit seen, idle;
    pulse_ack();
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL ackdone_pre: got %b want 0", valid); end
    frame_w = {16'($urandom), 16'($urandom)};
    pulse_start();
    wait_done(400, seen);
    checks++; if (!seen) begin fails++; $display("FAIL ackdone_timeout: got no done"); end
    pulse_ack();
    checks++; if ({valid, overrun} !== 2'b10) begin fails++; $display("FAIL ackdone_flags: got %b want 10", {valid, overrun}); end
    wait_idle(50, idle);
    pulse_ack();
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL ackdone_later_ack: got %b want 0", valid); end
  endtask

  task automatic test_random_frames();
    bit seen, idle, valid_m, overrun_m;
    logic [CH*DB-1:0] exp;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    valid_m   = 1'b0;
    overrun_m = 1'b0;
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack();
        valid_m = 1'b0;
      end
      frame_w = {16'($urandom), 16'($urandom)};
      exp_q.push_back(model_dato(frame_w));
      pulse_start();
      wait_done(400, seen);
      checks++; if (!seen) begin fails++; $display("FAIL rand_timeout: iter %0d got no done", it); end
      if (valid_m) overrun_m = 1'b1;
      valid_m = 1'b1;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      checks++; if (Dato !== exp) begin fails++; $display("FAIL rand_dato: iter %0d got %h want %h", it, Dato, exp); end
      checks++; if (data_basura !== model_lead(frame_w)) begin fails++; $display("FAIL rand_basura: iter %0d got %h want %h", it, data_basura, model_lead(frame_w)); end
      checks++; if ({valid, overrun} !== {valid_m, overrun_m}) begin fails++; $display("FAIL rand_flags: iter %0d got %b want %b", it, {valid, overrun}, {valid_m, overrun_m}); end
      wait_idle(50, idle);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_shot();
    test_leading_bits();
    test_continuous();
    test_overrun();
    test_reset_mid_frame();
    test_ack_with_done();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
